// File: rtl/writeback_stage.sv
// writeback_stage: retires ALU results and aligned, extended loads into the register file,
// flagging misaligned/illegal loads and memory timeouts without writing.
module writeback_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        RegWriteIn,
  input  logic        MemToReg,
  input  logic [4:0]  rd,
  input  logic [31:0] aluResult,
  input  logic [2:0]  funct3,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        RegWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic        err_misaligned,
  output logic        err_timeout
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0] rd_q, rd_d, wreg_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;
  logic [31:0] addr_d, wdata_d, sh, load_data;
  logic req_d, wr_d, mis_d, to_d, accept, legal, aligned, got;
  assign in_ready = state_q == IDLE;
  assign accept = in_valid && in_ready;
  assign legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign aligned = funct3[1:0] == 2'b01 ? !aluResult[0] :
                   funct3[1:0] == 2'b10 ? aluResult[1:0] == 2'b00 : 1'b1;
  // rvalid only counts once the request has been granted
  assign got = mem_rvalid && (state_q == WAIT || mem_gnt);
  assign sh = mem_rdata >> {off_q, 3'b000};
  assign load_data = f3_q[1:0] == 2'b00 ? {{24{sh[7] & !f3_q[2]}}, sh[7:0]} :
                     f3_q[1:0] == 2'b01 ? {{16{sh[15] & !f3_q[2]}}, sh[15:0]} : mem_rdata;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    f3_d = f3_q;
    off_d = off_q;
    addr_d = mem_addr;
    wreg_d = writeReg;
    wdata_d = writeData;
    req_d = 1'b0;
    wr_d = 1'b0;
    mis_d = 1'b0;
    to_d = 1'b0;
    case (state_q)
      IDLE: if (accept && RegWriteIn) begin
        if (!MemToReg) begin
          state_d = WRITE;
          wr_d = rd != 5'd0;
          wreg_d = rd;
          wdata_d = aluResult;
        end else if (legal && aligned) begin
          state_d = REQ;
          rd_d = rd;
          f3_d = funct3;
          off_d = aluResult[1:0];
          addr_d = {aluResult[31:2], 2'b00};
          cnt_d = '0;
          req_d = 1'b1;
        end else begin
          mis_d = 1'b1;
        end
      end
      REQ, WAIT: if (got) begin
        state_d = WRITE;
        wr_d = rd_q != 5'd0;
        wreg_d = rd_q;
        wdata_d = load_data;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d = IDLE;
        to_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        state_d = (state_q == REQ && !mem_gnt) ? REQ : WAIT;
        req_d = state_q == REQ && !mem_gnt;
      end
      WRITE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_q <= '0;
      f3_q <= '0;
      off_q <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      RegWrite <= 1'b0;
      writeReg <= '0;
      writeData <= '0;
      err_misaligned <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      f3_q <= f3_d;
      off_q <= off_d;
      mem_req <= req_d;
      mem_addr <= addr_d;
      RegWrite <= wr_d;
      writeReg <= wreg_d;
      writeData <= wdata_d;
      err_misaligned <= mis_d;
      err_timeout <= to_d;
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: randomized scoreboard bench; driver acts as memory and pushes expected
// register-file events, a monitor pops and compares every pulse the stage emits.
module tb_writeback_stage;
  localparam int T = 4;
  logic clock = 1'b0, reset_n = 1'b0;
  logic in_valid = 1'b0, RegWriteIn = 1'b0, MemToReg = 1'b0;
  logic [4:0] rd = '0;
  logic [31:0] aluResult = '0, mem_rdata = '0;
  logic [2:0] funct3 = '0;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic in_ready, mem_req, RegWrite, err_misaligned, err_timeout;
  logic [31:0] mem_addr, writeData;
  logic [4:0] writeReg;
  int total = 0, bad = 0;
  typedef struct {logic [2:0] kind; logic [4:0] r; logic [31:0] d;} ev_t;
  ev_t exp_q[$];

  writeback_stage #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .RegWriteIn(RegWriteIn), .MemToReg(MemToReg), .rd(rd), .aluResult(aluResult),
    .funct3(funct3), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .RegWrite(RegWrite),
    .writeReg(writeReg), .writeData(writeData), .err_misaligned(err_misaligned),
    .err_timeout(err_timeout));

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
    longint v;
    int n;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    v = (longint'(w) >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
    if (!f3[2] && n < 4 && v >= longint'(64'd1 << (8 * n - 1))) v -= longint'(64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic ev_t mk(input logic [2:0] k, input logic [4:0] r, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.r = r; e.d = d;
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset_n && (RegWrite || err_misaligned || err_timeout)) begin
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got kind=%b reg=%0d data=%h expected no event", {RegWrite, err_misaligned, err_timeout}, writeReg, writeData);
      end else begin
        e = exp_q.pop_front();
        if ({RegWrite, err_misaligned, err_timeout} !== e.kind || (e.kind[2] && (writeReg !== e.r || writeData !== e.d))) begin
          bad++;
          $display("FAIL sb_event: got kind=%b reg=%0d data=%h expected kind=%b reg=%0d data=%h", {RegWrite, err_misaligned, err_timeout}, writeReg, writeData, e.kind, e.r, e.d);
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clock);
    chk("idle_return", in_ready, 1'b1);
  endtask

  // starts and ends on a negedge with the stage idle; g/rv are the cycles after accept
  // in which mem_gnt / mem_rvalid are presented (rv >= g)
  task automatic txn(input logic rw, input logic m2r, input logic [4:0] r, input logic [31:0] a,
                     input logic [2:0] f3, input logic [31:0] w, input int g, input int rv);
    int n;
    logic ok;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && (int'(a[1:0]) % n == 0);
    chk("ready_before", in_ready, 1'b1);
    in_valid = 1'b1; RegWriteIn = rw; MemToReg = m2r; rd = r; aluResult = a; funct3 = f3;
    if (rw && !m2r && r != 0) exp_q.push_back(mk(3'b100, r, a));
    if (rw && m2r && !ok) exp_q.push_back(mk(3'b010, 0, 0));
    if (rw && m2r && ok && rv > T) exp_q.push_back(mk(3'b001, 0, 0));
    if (rw && m2r && ok && rv <= T && r != 0) exp_q.push_back(mk(3'b100, r, ref_load(w, a[1:0], f3)));
    @(negedge clock);
    in_valid = 1'b0;
    aluResult = $urandom;
    if (!rw) begin
      chk("skip_ready", in_ready, 1'b1);
      chk("skip_nowrite", RegWrite, 1'b0);
    end else if (!m2r) begin
      chk("alu_pulse", RegWrite, r != 0);
      chk("alu_busy", in_ready, 1'b0);
      @(negedge clock);
      chk("alu_pulse_end", RegWrite, 1'b0);
      chk("alu_ready", in_ready, 1'b1);
    end else if (!ok) begin
      chk("mis_pulse", err_misaligned, 1'b1);
      chk("mis_noreq", mem_req, 1'b0);
      chk("mis_ready", in_ready, 1'b1);
    end else begin
      for (int c = 1; c <= T + 3; c++) begin
        chk("mem_req", mem_req, c <= g && c <= T);
        if (mem_req) chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("ld_pulse", RegWrite, rv <= T && c == rv + 1 && r != 0);
        chk("to_pulse", err_timeout, rv > T && c == T + 1);
        mem_gnt = (c == g);
        mem_rvalid = (c == rv);
        mem_rdata = (c == rv) ? w : $urandom;
        @(negedge clock);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_req", mem_req, 0); chk("rst_wr", RegWrite, 0); chk("rst_mis", err_misaligned, 0);
    chk("rst_to", err_timeout, 0); chk("rst_addr", mem_addr, 0); chk("rst_wreg", writeReg, 0);
    chk("rst_wdata", writeData, 0); chk("rst_ready", in_ready, 1);
    reset_n = 1'b1;
    @(negedge clock);
    txn(1, 0, 5, 32'h0000_1234, 3'b000, 0, 0, 0);
    txn(1, 1, 9, 32'h0000_0102, 3'b000, 32'h0080_0000, 1, 3);
    txn(1, 1, 9, 32'h0000_0102, 3'b100, 32'h0080_0000, 1, 3);
    txn(1, 1, 10, 32'h0000_0206, 3'b001, 32'h8001_7FFF, 2, 2);
    txn(1, 1, 10, 32'h0000_0205, 3'b001, 32'h8001_7FFF, 1, 1);
    txn(1, 1, 11, 32'h0000_0300, 3'b010, 32'h1234_5678, 1, T + 2);
    txn(1, 0, 0, 32'hDEAD_BEEF, 3'b000, 0, 0, 0);
    txn(1, 1, 12, 32'h0000_0400, 3'b010, 32'hCAFE_F00D, 1, 1);
    txn(1, 1, 13, 32'h0000_0400, 3'b011, 32'hCAFE_F00D, 1, 1);
    txn(0, 1, 14, 32'h0000_0400, 3'b010, 32'hCAFE_F00D, 1, 1);
    // reset while waiting for read data: the load must vanish without a write
    in_valid = 1'b1; RegWriteIn = 1; MemToReg = 1; rd = 7; aluResult = 32'h40; funct3 = 3'b010;
    @(negedge clock);
    in_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clock);
    mem_gnt = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 0); chk("mid_rst_wr", RegWrite, 0); chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wreg", writeReg, 0); chk("mid_rst_wdata", writeData, 0); chk("mid_rst_ready", in_ready, 1);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    mem_rvalid = 1'b0;
    @(negedge clock);
    chk("post_rst_wr", RegWrite, 0);
    chk("post_rst_ready", in_ready, 1);
    for (int i = 0; i < 150; i++) begin
      int g, rv;
      g = $urandom_range(1, T + 1);
      rv = $urandom_range(g, T + 2);
      txn($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 60, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
          $urandom, 3'($urandom), $urandom, g, rv);
      if ($urandom_range(0, 3) == 0) @(negedge clock);
    end
    repeat (4) @(negedge clock);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
